// File: rtl/pixel_stream_packer.sv
// Packs 24-bit RGB pixels densely into a 32-bit AXI4-Stream video master (4 pixels -> 3 words).
// Optional protocol-error counter enabled by defining PIXEL_STREAM_PACKER_ERRCNT_EN.
module pixel_stream_packer #(
    parameter int unsigned RGB_LANE_ORDER = 0,
    parameter int unsigned FIFO_DEPTH     = 3,
    parameter int unsigned ERRCNT_W       = 16
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [7:0]          in_r,
    input  logic [7:0]          in_g,
    input  logic [7:0]          in_b,
    input  logic                in_valid,
    input  logic                in_sof,
    input  logic                in_eol,
    output logic                in_ready,
    output logic [31:0]         m_axis_tdata,
    output logic [3:0]          m_axis_tkeep,
    output logic                m_axis_tuser,
    output logic                m_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        user;
        logic        last;
    } word_t;

    word_t            fifo_q [FIFO_DEPTH];
    word_t            fifo_d [FIFO_DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [23:0]      acc_q, acc_d;
    logic [1:0]       acc_cnt_q, acc_cnt_d;
    logic             sof_pend_q, sof_pend_d;
    logic             rdy_q, rdy_d;
    logic             valid_q, valid_d;

    logic [23:0]      pix;
    logic             xfer;
    logic             pop;
    logic [1:0]       base_cnt;
    logic [23:0]      base_acc;
    logic [47:0]      merged;
    logic [2:0]       n;
    logic             full;
    logic [1:0]       rem_cnt;
    logic [23:0]      rem_data;
    logic [3:0]       rem_keep;
    logic             sof_eff;
    word_t            push0, push1;
    logic [1:0]       npush;
    logic [CNT_W-1:0] base;

    // Accumulator merge and word generation for the current beat
    always_comb begin
        pix        = (RGB_LANE_ORDER == 0) ? {in_r, in_g, in_b} : {in_b, in_g, in_r};
        xfer       = in_valid && rdy_q;
        // A new frame discards any residual bytes left by a missing EOL
        base_cnt   = in_sof ? 2'd0 : acc_cnt_q;
        base_acc   = in_sof ? 24'd0 : acc_q;
        merged     = {24'd0, base_acc} | ({24'd0, pix} << {base_cnt, 3'b000});
        n          = {1'b0, base_cnt} + 3'd3;
        full       = (n >= 3'd4);
        rem_cnt    = full ? 2'(n - 3'd4) : 2'(n);
        rem_data   = full ? {8'd0, merged[47:32]} : merged[23:0];
        sof_eff    = sof_pend_q || in_sof;
        case (rem_cnt)
            2'd1:    rem_keep = 4'b0001;
            2'd2:    rem_keep = 4'b0011;
            2'd3:    rem_keep = 4'b0111;
            default: rem_keep = 4'b0000;
        endcase

        push0      = '0;
        push1      = '0;
        npush      = 2'd0;
        sof_pend_d = sof_pend_q;
        acc_d      = acc_q;
        acc_cnt_d  = acc_cnt_q;

        if (xfer) begin
            if (full) begin
                push0.data = merged[31:0];
                push0.keep = 4'hF;
                npush      = 2'd1;
                if (in_eol && rem_cnt != 2'd0) begin
                    push1.data = {8'd0, rem_data};
                    push1.keep = rem_keep;
                    push1.last = 1'b1;
                    npush      = 2'd2;
                end else begin
                    push0.last = in_eol;
                end
            end else if (in_eol) begin
                push0.data = {8'd0, rem_data};
                push0.keep = rem_keep;
                push0.last = 1'b1;
                npush      = 2'd1;
            end
            if (npush != 2'd0) begin
                push0.user = sof_eff;
            end
            sof_pend_d = sof_eff && (npush == 2'd0);
            acc_d      = in_eol ? 24'd0 : rem_data;
            acc_cnt_d  = in_eol ? 2'd0 : rem_cnt;
        end
    end

    // Shift-register FIFO: slot 0 is the head, pushes land just above the survivors
    always_comb begin
        pop  = valid_q && m_axis_tready;
        base = cnt_q - CNT_W'(pop);
        for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
            fifo_d[i] = pop ? fifo_q[i+1] : fifo_q[i];
        end
        fifo_d[FIFO_DEPTH-1] = pop ? '0 : fifo_q[FIFO_DEPTH-1];
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (npush != 2'd0 && CNT_W'(i) == base) begin
                fifo_d[i] = push0;
            end
            if (npush == 2'd2 && CNT_W'(i) == base + CNT_W'(1)) begin
                fifo_d[i] = push1;
            end
        end
        cnt_d   = cnt_q - CNT_W'(pop) + CNT_W'(npush);
        valid_d = (cnt_d != '0);
        // Two free slots cover the worst-case two-word beat
        rdy_d   = (cnt_d <= CNT_W'(FIFO_DEPTH - 2));
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
            cnt_q      <= '0;
            acc_q      <= '0;
            acc_cnt_q  <= '0;
            sof_pend_q <= 1'b0;
            rdy_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= fifo_d[i];
            end
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            acc_cnt_q  <= acc_cnt_d;
            sof_pend_q <= sof_pend_d;
            rdy_q      <= rdy_d;
            valid_q    <= valid_d;
        end
    end

    assign in_ready      = rdy_q;
    assign m_axis_tvalid = valid_q;
    assign m_axis_tdata  = fifo_q[0].data;
    assign m_axis_tkeep  = fifo_q[0].keep;
    assign m_axis_tuser  = fifo_q[0].user;
    assign m_axis_tlast  = fifo_q[0].last;

`ifdef PIXEL_STREAM_PACKER_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_q;
    logic                resid_err;

    assign resid_err = xfer && in_sof && (acc_cnt_q != 2'd0);

    // Saturating count of frames started with residual bytes
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            err_q <= '0;
        end else if (resid_err && err_q != '1) begin
            err_q <= err_q + ERRCNT_W'(1);
        end
    end

    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: doc/pixel_stream_packer.md
Name: pixel_stream_packer

Overview:
- Sits directly downstream of the ray-tracer pixel buffer.
- Takes one 24-bit RGB pixel per beat, with start-of-frame (SOF) and end-of-line (EOL) flags, and packs pixels densely into a 32-bit AXI4-Stream video master.
- Four pixels fill three words. Every line ends on a word boundary, with a partial last word marked by tkeep.
- tuser marks frame start and tlast marks line end, for the VDMA/video-out path.

Parameters:
- RGB_LANE_ORDER, 0, byte order within a pixel. 0: byte0=b, byte1=g, byte2=r. 1: byte0=r, byte1=g, byte2=b.
- FIFO_DEPTH, 3, depth of the output word FIFO. Must be ≥3.
- ERRCNT_W, 16, width of the protocol-error counter.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- in_r  in  8  pixel red
- in_g  in  8  pixel green
- in_b  in  8  pixel blue
- in_valid  in  1  pixel present
- in_sof  in  1  first pixel of frame
- in_eol  in  1  last pixel of line
- in_ready  out  1  packer can accept a pixel; feeds the pixel buffer's downstream-ready input
- m_axis_tdata  out  32  packed word
- m_axis_tkeep  out  4  byte enables
- m_axis_tuser  out  1  start of frame
- m_axis_tlast  out  1  end of line
- m_axis_tvalid  out  1  word valid
- m_axis_tready  in  1  sink ready
- err_count  out  ERRCNT_W  protocol-error count (see Optional Feature)

Behaviour:
- Clock and reset: one clock, aclk. Reset is asynchronous and active-high on areset; all state is cleared on assertion.
- Reset values: FIFO empty, accumulator count 0, sof_pending 0, err_count 0. Outputs: tvalid 0, tdata/tkeep/tuser/tlast 0, in_ready 0 while areset is high and 1 on the first clock after release.
- Reset mid-operation: partial words and FIFO contents are discarded. No word is emitted after reset.
- Pixel transfer: a pixel transfers when in_valid && in_ready.
- in_ready = (fifo_count ≤ FIFO_DEPTH-2), from registered state only. It has no combinational path from in_valid or m_axis_tready, because upstream asserts valid only after seeing ready.
- Accumulator: 48-bit byte accumulator with count acc_cnt in 0..3 between beats.
  - On transfer, the 3 pixel bytes are appended above the existing bytes, giving a new count n = acc_cnt+3 (3..6).
  - If n ≥ 4: push the low 4 bytes with tkeep=1111, shift the remainder down, acc_cnt = n-4.
  - If in_eol: the remaining bytes (if any) are pushed as a further word with tkeep = (1<<rem)-1, upper bytes 0, and acc_cnt = 0. tlast=1 goes on the final word pushed for that pixel.
  - A single beat therefore pushes at most 2 words; the FIFO headroom rule guarantees space for both.
- tuser:
  - in_sof sets sof_pending.
  - The first word pushed at or after that beat carries tuser=1, and sof_pending then clears.
  - If SOF and EOL on a 1-pixel line produce one word, that word has tuser=1 and tlast=1.
- Latency and throughput:
  - A word pushed at edge N is visible on the master at edge N+1 if the FIFO was empty, i.e. 1-cycle latency.
  - With m_axis_tready=1, sustained 1 pixel/cycle is supported.
- AXI rules:
  - Once tvalid rises, tdata/tkeep/tuser/tlast are held stable until tready.
  - A pop and a push in the same cycle update fifo_count by the net change.
- SOF with acc_cnt ≠ 0 (missing EOL):
  - The residual bytes are dropped and the accumulator restarts at the SOF pixel.
  - This counts as a protocol error.
- EOL with acc_cnt = 0 and n = 3 pushes one word with tkeep=0111.

Optional Feature:
- Macro: PIXEL_STREAM_PACKER_ERRCNT_EN.
- Defined: err_count increments by 1 on each SOF-with-residual event. It saturates at all-ones and is cleared only by areset.
- Undefined: the counter logic is omitted and err_count is tied to 0. Data-path behaviour, including the residual drop, is identical either way.

Test Plan:
- Line of 4 pixels with rgb 112233, 445566, 778899, AABBCC; SOF on pixel 1, EOL on pixel 4; RGB_LANE_ORDER=0, tready=1 → three words:
  - 0x66112233 (tuser=1)
  - 0x88994455
  - 0xAABBCC77 (tlast=1)
  - all with tkeep=1111.
- 1-pixel line, SOF+EOL, rgb 112233 → one word 0x00112233, tkeep=0111, tuser=1, tlast=1.
- 2-pixel line 112233, 445566 with EOL on pixel 2 → words 0x66112233 (keep 1111), then 0x00004455 (keep 0011, tlast=1).
- tready held 0 for 10 cycles during a continuous pixel stream → in_ready drops once fifo_count ≥ FIFO_DEPTH-1. tdata is stable while stalled. After release, all words arrive in order with none lost or duplicated.
- 2 pixels without EOL, then SOF → residual 2 bytes dropped. Next words start at the SOF pixel. err_count=1 with the macro defined, 0 without it.
- Assert areset mid-line with 2 words in the FIFO → tvalid falls immediately (async) and in_ready=0 while areset is high. After release the FIFO is empty, in_ready=1, and a fresh 4-pixel line yields exactly 3 correct words.
